// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus from three sources plus the shared register-file write port.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [2:0]          req_valid;
  logic [3*ADDR_W-1:0] req_waddr;
  logic [3*DATA_W-1:0] req_wdata;
  logic [2:0]          req_ready;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic [1:0]          grant_id;
  logic                starve_evt;

  // Arbiter side
  modport slave (
    input  req_valid, req_waddr, req_wdata,
    output req_ready, we, waddr, wdata, grant_id, starve_evt
  );

  // Sources / register-file side
  modport master (
    output req_valid, req_waddr, req_wdata,
    input  req_ready, we, waddr, wdata, grant_id, starve_evt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU, load and mul/div
// writeback using fixed priority with aging; the winning write is registered.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_en,
  regfile_wb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    SRC_ALU    = 2'd0,
    SRC_LOAD   = 2'd1,
    SRC_MULDIV = 2'd2,
    SRC_NONE   = 2'd3
  } src_e;

  logic [WAIT_W-1:0] r_wait [3];
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  src_e              r_gid;

  logic [2:0]        w_starved;
  logic [2:0]        w_grant;
  src_e              w_sel;
  logic              w_starve;
  logic [ADDR_W-1:0] w_sel_waddr;
  logic [DATA_W-1:0] w_sel_wdata;

  always_comb begin
    w_starved = '0;
    for (int unsigned i = 0; i < 3; i++)
      w_starved[i] = bus.req_valid[i] && (r_wait[i] == WAIT_W'(MAX_WAIT));
  end

  // A starved requester overrides the fixed priority; ties go to the lowest index.
  always_comb begin
    w_sel    = SRC_NONE;
    w_starve = 1'b0;
    if (rst && wb_en && (|bus.req_valid)) begin
      if (|w_starved) begin
        w_starve = 1'b1;
        if (w_starved[0])      w_sel = SRC_ALU;
        else if (w_starved[1]) w_sel = SRC_LOAD;
        else                   w_sel = SRC_MULDIV;
      end else if (bus.req_valid[0]) begin
        w_sel = SRC_ALU;
      end else if (bus.req_valid[1]) begin
        w_sel = SRC_LOAD;
      end else begin
        w_sel = SRC_MULDIV;
      end
    end
  end

  always_comb begin
    w_grant     = '0;
    w_sel_waddr = '0;
    w_sel_wdata = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (w_sel == src_e'(i)) begin
        w_grant[i]  = 1'b1;
        w_sel_waddr = bus.req_waddr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.req_ready  = w_grant;
  assign bus.starve_evt = w_starve;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 3; i++) r_wait[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (w_grant[i] || !bus.req_valid[i])
          r_wait[i] <= '0;
        else if (wb_en && (r_wait[i] != WAIT_W'(MAX_WAIT)))
          r_wait[i] <= r_wait[i] + 1'b1;
      end
    end
  end

  // Address 0 is consumed like any other write but never reaches the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_gid   <= SRC_NONE;
    end else if (w_sel != SRC_NONE) begin
      r_we    <= |w_sel_waddr;
      r_waddr <= w_sel_waddr;
      r_wdata <= w_sel_wdata;
      r_gid   <= w_sel;
    end else begin
      r_we    <= 1'b0;
      r_gid   <= SRC_NONE;
    end
  end

  assign bus.we       = r_we;
  assign bus.waddr    = r_waddr;
  assign bus.wdata    = r_wdata;
  assign bus.grant_id = r_gid;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we/waddr/wdata) between three writeback sources: 0 = ALU, 1 = load unit, 2 = multicycle mul/div unit.
- Each cycle it grants at most one source using fixed priority with aging, so no source starves.
- It registers the winning write and drives it onto the register-file write port one cycle after the grant.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width (32 registers)
MAX_WAIT, 4, consecutive blocked cycles after which a source is marked starved
WAIT_W, 3, wait-counter width; must hold MAX_WAIT

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
wb_en  in  1  writeback enable; low = pipeline stall, no grants issued
req_valid  in  3  per-source write request, bit i = source i
req_waddr  in  3*ADDR_W  source i address at bits [i*ADDR_W +: ADDR_W]
req_wdata  in  3*DATA_W  source i data at bits [i*DATA_W +: DATA_W]
req_ready  out  3  one-hot grant; handshake when valid[i] && ready[i]
we  out  1  register-file write enable
waddr  out  ADDR_W  register-file write address
wdata  out  DATA_W  register-file write data
grant_id  out  2  source index of the write currently on we/waddr/wdata; 3 = none
starve_evt  out  1  one-cycle pulse: the grant in this cycle was an aging override

Behaviour:
- Reset (rst low, immediate, asynchronous):
  - we=0, waddr=0, wdata=0, grant_id=3, starve_evt=0.
  - All wait counters cleared to 0.
  - req_ready is combinational and is 0 while rst is low.
- Source protocol:
  - A source holds valid, waddr and wdata stable until it sees ready.
  - Dropping valid before ready is permitted; its counter then clears.
- Grant (combinational, evaluated each cycle):
  - No grant when wb_en=0 or no valid is set. Otherwise exactly one ready bit is set.
  - If any source has wait_cnt[i]==MAX_WAIT and valid[i]=1, grant the lowest such index and assert starve_evt.
  - Else fixed priority: 0 > 1 > 2.
- Wait counters, one per source, updated each rising edge:
  - Cleared to 0 when the source is granted or valid[i]=0.
  - Held when wb_en=0.
  - Otherwise incremented, saturating at MAX_WAIT.
- Output register (latency 1):
  - On the edge after a handshake on source i: waddr=req_waddr[i], wdata=req_wdata[i], grant_id=i.
  - we=1 unless req_waddr[i]==0; address 0 is accepted and consumed but written with we=0.
  - With no handshake: we=0, grant_id=3, waddr/wdata hold their previous values.
- Starvation bound: a source with valid held and wb_en=1 is granted within MAX_WAIT+3 cycles of raising valid.
- Simultaneous requests to the same address from different sources:
  - Writes issue in grant order; the later grant's data persists.
  - The register file's write-to-read bypass covers same-cycle reads.
- wb_en falling while the output register holds a write: that write still completes next edge; only new grants stop.
- Reset asserted mid-operation: the pending output write is discarded (we=0 immediately). Sources must re-present their requests after reset releases.

Test Plan:
- Reset: rst=0 with all valid=1 -> req_ready=000, we=0, grant_id=3. Release rst, wb_en=1 -> ready=001 same cycle; next edge we=1 with source 0 address/data, grant_id=0.
- Priority: valid=110 with addr1=5/data1=0x11111111, addr2=6/data2=0x22222222 -> cycle0 ready=010, cycle1 we=1 waddr=5; cycle1 ready=100, cycle2 waddr=6, wdata=0x22222222.
- Aging: valid0 held high continuously, valid2=1 with MAX_WAIT=4 -> source 2 blocked 4 cycles, granted in cycle 4 with starve_evt=1; grant_id=2 in cycle 5; source 0 regains grant in cycle 5.
- Address zero: source 1 addr=0, data=0xDEADBEEF -> ready=010 handshake; next cycle we=0, grant_id=1.
- Stall: wb_en=0 for 3 cycles with valid=100 -> ready=000, counter held at its pre-stall value. wb_en=1 -> immediate grant to source 2.
- Async reset mid-write: assert rst low between edges while we=1 -> we drops to 0 without a clock edge; counters read 0 after release.
